// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write bus for imem_loader.
// master = loader side, slave = stream source / memory side.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    modport master (
        input  s_valid, s_data,
        output s_ready, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, mem_we, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory program loader: byte stream -> little-endian 32-bit words, holds CPU until done.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        BYTE  = 3'd3,
        WRITE = 3'd4,
`ifdef IMEM_LOADER_CSUM_EN
        CSUM  = 3'd5,
`endif
        DONE  = 3'd6,
        ERROR = 3'd7
    } state_t;

    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    state_t            state_q;
    logic [15:0]       cnt_q;
    logic [ADDR_W:0]   word_idx_q;
    logic [1:0]        byte_idx_q;
    logic [2:0][7:0]   lane_q;
    logic [ADDR_W-1:0] mem_waddr_q;
    logic [31:0]       mem_wdata_q;
    logic              cpu_hold_q;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]        acc_q;
`endif

    logic              accept;
    logic [15:0]       n_hdr;
    logic [ADDR_W:0]   word_next;

    assign accept    = bus.s_valid && bus.s_ready;
    assign n_hdr     = {bus.s_data, cnt_q[7:0]};
    assign word_next = word_idx_q + (ADDR_W+1)'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            lane_q      <= '0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
            acc_q       <= '0;
`endif
        end else begin
`ifdef IMEM_LOADER_CSUM_EN
            if (accept && state_q != CSUM) acc_q <= acc_q ^ bus.s_data;
`endif
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_q    <= HDR0;
                        word_idx_q <= '0;
                        byte_idx_q <= '0;
                        cpu_hold_q <= 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
                        acc_q      <= '0;
`endif
                    end
                end
                HDR0: begin
                    if (accept) begin
                        cnt_q[7:0] <= bus.s_data;
                        state_q    <= HDR1;
                    end
                end
                HDR1: begin
                    if (accept) begin
                        cnt_q[15:8] <= bus.s_data;
                        if ({1'b0, n_hdr} > CAP) begin
                            state_q <= ERROR;
                        end else if (n_hdr == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
                            state_q    <= CSUM;
`else
                            state_q    <= DONE;
                            cpu_hold_q <= 1'b0;
`endif
                        end else begin
                            state_q <= BYTE;
                        end
                    end
                end
                BYTE: begin
                    if (accept) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: lane_q[0] <= bus.s_data;
                            2'd1: lane_q[1] <= bus.s_data;
                            2'd2: lane_q[2] <= bus.s_data;
                            default: begin
                                // 4th byte goes straight into the write register, no lane needed
                                mem_wdata_q <= {bus.s_data, lane_q[2], lane_q[1], lane_q[0]};
                                mem_waddr_q <= word_idx_q[ADDR_W-1:0];
                                state_q     <= WRITE;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    word_idx_q <= word_next;
                    byte_idx_q <= '0;
                    if (17'(word_next) == {1'b0, cnt_q}) begin
`ifdef IMEM_LOADER_CSUM_EN
                        state_q    <= CSUM;
`else
                        state_q    <= DONE;
                        cpu_hold_q <= 1'b0;
`endif
                    end else begin
                        state_q <= BYTE;
                    end
                end
`ifdef IMEM_LOADER_CSUM_EN
                CSUM: begin
                    if (accept) begin
                        if (bus.s_data == acc_q) begin
                            state_q    <= DONE;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= ERROR;
                        end
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef IMEM_LOADER_CSUM_EN
    assign bus.s_ready = (state_q == HDR0) || (state_q == HDR1) || (state_q == BYTE) ||
                         (state_q == CSUM);
`else
    assign bus.s_ready = (state_q == HDR0) || (state_q == HDR1) || (state_q == BYTE);
`endif
    assign bus.mem_we    = (state_q == WRITE);
    assign bus.mem_waddr = mem_waddr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign busy          = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
    assign done          = (state_q == DONE);
    assign error         = (state_q == ERROR);
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of loads plus reset-mid-load sequence, write scoreboard.
module tb_imem_loader;
    localparam int unsigned ADDR_W = 8;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic cpu_hold, busy, done, error;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int nwrites = 0;
    logic [7:0] acc;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [15:0] n;
        logic [31:0] base;
        logic [31:0] step;
        bit          gaps;
        bit          poke;
        bit          corrupt;
        int          exp_writes;
        bit          exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_t e;
            nwrites++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected write: got addr %h data %h expected none",
                         bus.mem_waddr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("mem_waddr", 32'(bus.mem_waddr), 32'(e.addr));
                check("mem_wdata", bus.mem_wdata, e.data);
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the accepting posedge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int g = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus.s_valid = 1'b0;
                bus.s_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        while (bus.s_ready !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) begin
            checks++;
            errors++;
            $display("FAIL handshake timeout: got s_ready %b expected 1", bus.s_ready);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_data  = 8'($urandom);
        acc ^= b;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " s_ready"},   32'(bus.s_ready),   32'd0);
        check({tag, " mem_we"},    32'(bus.mem_we),    32'd0);
        check({tag, " mem_waddr"}, 32'(bus.mem_waddr), 32'd0);
        check({tag, " mem_wdata"}, bus.mem_wdata,      32'd0);
        check({tag, " cpu_hold"},  32'(cpu_hold),      32'd1);
        check({tag, " busy"},      32'(busy),          32'd0);
        check({tag, " done"},      32'(done),          32'd0);
        check({tag, " error"},     32'(error),         32'd0);
    endtask

    task automatic run_load(input vec_t v);
        logic [31:0] w;
        logic [7:0]  cs;
        int          w0;
        bit          hdr_err;
        w0      = nwrites;
        acc     = 8'h00;
        hdr_err = (32'(v.n) > (32'd1 << ADDR_W));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy after start",     32'(busy),        32'd1);
        check("cpu_hold after start", 32'(cpu_hold),    32'd1);
        check("s_ready in HDR0",      32'(bus.s_ready), 32'd1);
        check("done after start",     32'(done),        32'd0);
        send_byte(v.n[7:0], v.gaps);
        send_byte(v.n[15:8], v.gaps);
        if (v.poke) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        w = v.base;
        for (int i = 0; i < v.exp_writes; i++) begin
            exp_q.push_back('{addr: ADDR_W'(i), data: w});
            for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], v.gaps);
            check("mem_we after 4th byte", 32'(bus.mem_we), 32'd1);
            check("done during WRITE",     32'(done),       32'd0);
            w = w + v.step;
        end
`ifdef IMEM_LOADER_CSUM_EN
        if (!hdr_err) begin
            cs = v.corrupt ? (acc ^ 8'h01) : acc;
            send_byte(cs, v.gaps);
        end
`else
        cs = 8'h00;
        if (v.exp_writes != 0) @(negedge clk);
`endif
        check("done",         32'(done),        32'(!v.exp_err));
        check("error",        32'(error),       32'(v.exp_err));
        check("cpu_hold",     32'(cpu_hold),    32'(v.exp_err));
        check("busy at end",  32'(busy),        32'd0);
        check("s_ready idle", 32'(bus.s_ready), 32'd0);
        check("write count",  32'(nwrites - w0), 32'(v.exp_writes));
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        if (cs == 8'hff) check("csum byte", 32'(cs), 32'(acc ^ acc ^ cs));
        @(negedge clk);
        check("done holds", 32'(done), 32'(!v.exp_err));
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{16'd3,     32'h00a00093, 32'h00100080, 0, 0, 0, 3,   0});
        vecs.push_back('{16'd0,     32'h0,        32'h0,        0, 0, 0, 0,   0});
        vecs.push_back('{16'd3,     32'h00a00093, 32'h00100080, 1, 0, 0, 3,   0});
        vecs.push_back('{16'h0101,  32'h0,        32'h0,        0, 0, 0, 0,   1});
        vecs.push_back('{16'd1,     32'hdeadbeef, 32'h0,        0, 1, 0, 1,   0});
        vecs.push_back('{16'h0100,  32'h12345678, 32'h9e3779b9, 0, 0, 0, 256, 0});
`ifdef IMEM_LOADER_CSUM_EN
        vecs.push_back('{16'd3,     32'h00a00093, 32'h00100080, 0, 0, 1, 3,   1});
`endif
        vecs.push_back('{16'd3,     32'h00a00093, 32'h00100080, 1, 0, 0, 3,   0});

        reset       = 1'b1;
        start       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        #1;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("idle");

        foreach (vecs[k]) run_load(vecs[k]);

        // Reset in the middle of the second word, then a full reload from address 0.
        acc   = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        exp_q.push_back('{addr: ADDR_W'(0), data: 32'h00a00093});
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        send_byte(8'ha0, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h01, 0);
        check("busy mid-load", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("mid-load reset");
        check("scoreboard before reset", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_load(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
